imem_uart_loader: RTL and testbench
===================================

# imem_uart_loader

Serial program loader for the multicycle RISC-V core. Receives a program over a UART line (8N1, LSB first), assembles little-endian bytes into 32-bit instruction words, and writes them sequentially into instruction memory from word 0. It holds the core in reset until the program terminator (word 0x00000000) has been stored or memory is full, then releases it. The core's execution loop therefore sees a complete program ending in the zero instruction that drives it to FIM.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
- ADDR_W, 5, instruction memory word-address width (2^ADDR_W words)

- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- rx  in  1  UART serial input, idle high, asynchronous to clk
- imem_we  out  1  one-cycle instruction memory write strobe
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  32  instruction word for the write
- word_count  out  ADDR_W+1  number of words written so far
- core_rst_n  out  1  active-low reset to the core; 0 while loading
- load_done  out  1  program stored, core released; sticky
- frame_err  out  1  stop bit sampled low; sticky until rst

## Operation
- Input sync: rx passes through a 2-FF synchronizer (reset value 1); all decisions use the synchronized value rxs.
- RX sub-FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: rxs==0 -> R_START, bit counter cleared.
  - R_START: after CLKS_PER_BIT/2 cycles, sample rxs. 0 -> R_DATA. 1 -> glitch, back to R_IDLE with no byte and no error.
  - R_DATA: every CLKS_PER_BIT cycles sample one bit into shift[7] with a right shift. After 8 bits -> R_STOP.
  - R_STOP: after CLKS_PER_BIT cycles sample rxs. 1 -> byte_valid for one cycle, then R_IDLE. 0 -> frame error.
- Loader FSM states: L_LOAD, L_WRITE, L_DONE, L_ERR.
  - L_LOAD: on byte_valid, store the byte at bits [8*idx+7:8*idx] of the word buffer, with idx = 0..3 (first byte = bits 7:0), then idx++. When idx was 3 -> L_WRITE.
  - L_WRITE: hold imem_we=1 for exactly one cycle with imem_addr = word_count[ADDR_W-1:0] and imem_wdata = buffer; word_count++ and idx = 0.
    - Buffer == 0, or word_count reaches 2^ADDR_W -> L_DONE.
    - Otherwise -> L_LOAD.
  - The terminator word is written to memory before L_DONE.
  - L_DONE: load_done=1, core_rst_n=1. Further rx traffic is ignored; RX may keep decoding, but no writes occur.
  - L_ERR: entered from any loader state except L_DONE on a frame error. frame_err=1, core_rst_n stays 0, no further writes. Exit only via rst.
  - A frame error after L_DONE is ignored; frame_err stays 0.
- Reset value of word_count, idx, buffer and shift register: 0.

## Timing
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, core_rst_n=0, load_done=0, frame_err=0; states R_IDLE/L_LOAD.
- A reset mid-byte or mid-word discards the partial data. Memory contents are not cleared.
- Synchronizer latency is 2 cycles from the rx edge to rxs.
- Start bit is checked CLKS_PER_BIT/2 cycles after rxs falls. Data bit n is sampled (n+1)*CLKS_PER_BIT cycles after that, and the stop bit 9*CLKS_PER_BIT after it.
- byte_valid fires in the stop-sample cycle.
- imem_we is asserted in the cycle after byte_valid of the 4th byte. imem_addr and imem_wdata are stable in that same cycle.
- word_count updates on the edge that ends the imem_we cycle.
- load_done and core_rst_n rise on that same edge, i.e. the cycle after the terminator's imem_we.
- frame_err rises the cycle after the failing stop sample.
- Back-to-back bytes, with a new start bit immediately after the stop bit, are accepted with no idle gap required. The L_WRITE cycle never drops a byte, since the next byte cannot complete within 1 cycle.

## Test plan
Use CLKS_PER_BIT=8 and ADDR_W=3 throughout.
- Program load: send bytes 93 00 10 00, 13 01 20 00, 00 00 00 00.
  - Expect three imem_we pulses: addr0=0x00100093, addr1=0x00200113, addr2=0x00000000.
  - Expect word_count=3, and load_done=core_rst_n=1 the cycle after the third pulse.
- Memory full: send 8 nonzero words. Expect 8 writes to addr 0..7, word_count=8, load_done=1 after the 8th write, and no 9th write when a further word is sent.
- Framing error: send byte 0x55 with stop bit 0 during word 1. Expect frame_err=1, no imem_we, core_rst_n=0; subsequent valid bytes produce no writes.
- Glitch rejection: drive rx low for 2 cycles, then high. Expect no byte_valid, no frame_err, and state back in R_IDLE; a following valid word is written at addr0.
- Reset mid-word: send 2 bytes, pulse rst low for 1 cycle, then send 0x13 0x05 0x10 0x00 0x00 0x00 0x00 0x00. Expect addr0=0x00100513, addr1=0, then load_done.
- Post-done traffic: after load_done, send 4 more bytes, including one with a bad stop bit. Expect no imem_we, frame_err=0, and load_done/core_rst_n to remain 1.

Source files
------------

// File: rtl/imem_uart_loader.sv
// imem_uart_loader
//   Receives a program over a UART line (8N1, LSB first), packs little-endian
//   bytes into 32-bit instruction words and writes them into instruction memory
//   from word 0 upward. The core is held in reset until the terminator word
//   (0x00000000) has been stored or memory is full.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 4)
//   ADDR_W        instruction memory word-address width
//
// Ports
//   clk         system clock, posedge
//   rst         synchronous, active-low reset
//   rx          UART serial input, idle high, asynchronous to clk
//   imem_we     one-cycle instruction memory write strobe
//   imem_addr   word address of the write
//   imem_wdata  instruction word of the write
//   word_count  number of words written so far
//   core_rst_n  active-low core reset, released once the program is stored
//   load_done   program stored, core released (sticky)
//   frame_err   stop bit sampled low during loading (sticky until rst)
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W:0]  MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_LOAD, L_WRITE, L_DONE, L_ERR} ld_state_t;

  // Two-stage synchronizer; rxs_q is the only rx value the FSMs look at.
  logic sync1_q, rxs_q;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid;
  logic             stop_err;

  ld_state_t        ld_state_q, ld_state_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      buf_q, buf_d;
  logic [ADDR_W:0]  word_count_q, word_count_d;
  logic             load_byte;
  logic [3:0]       lane_hit;

  // UART receiver: samples each bit at its middle.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rxs_q) begin
          rx_state_d = R_START;
          cnt_d      = '0;
          bit_cnt_d  = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          rx_state_d = rxs_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d     = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = R_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d      = '0;
          rx_state_d = R_IDLE;
          byte_valid = rxs_q;
          stop_err   = !rxs_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Byte lanes of the word buffer: byte idx lands in bits [8*idx+7:8*idx].
  assign load_byte = (ld_state_q == L_LOAD) && byte_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_hit[gi] = load_byte && (idx_q == 2'(gi));
      assign buf_d[8*gi +: 8] = lane_hit[gi] ? shift_q : buf_q[8*gi +: 8];
    end
  endgenerate

  // Loader FSM.
  always_comb begin
    ld_state_d   = ld_state_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;
    case (ld_state_q)
      L_LOAD: begin
        if (stop_err) begin
          ld_state_d = L_ERR;
        end else if (byte_valid) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == 2'd3) begin
            ld_state_d = L_WRITE;
          end
        end
      end
      L_WRITE: begin
        word_count_d = word_count_q + 1'b1;
        idx_d        = '0;
        if (stop_err) begin
          ld_state_d = L_ERR;
        end else if ((buf_q == 32'd0) || (word_count_d == MEM_WORDS)) begin
          ld_state_d = L_DONE;
        end else begin
          ld_state_d = L_LOAD;
        end
      end
      L_DONE:  ld_state_d = L_DONE;
      L_ERR:   ld_state_d = L_ERR;
      default: ld_state_d = L_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      rx_state_q   <= R_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      ld_state_q   <= L_LOAD;
      idx_q        <= '0;
      buf_q        <= '0;
      word_count_q <= '0;
    end else begin
      sync1_q      <= rx;
      rxs_q        <= sync1_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ld_state_q   <= ld_state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      word_count_q <= word_count_d;
    end
  end

  assign imem_we    = (ld_state_q == L_WRITE);
  assign imem_addr  = word_count_q[ADDR_W-1:0];
  assign imem_wdata = buf_q;
  assign word_count = word_count_q;
  assign load_done  = (ld_state_q == L_DONE);
  assign core_rst_n = load_done;
  assign frame_err  = (ld_state_q == L_ERR);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader (CLKS_PER_BIT=8, ADDR_W=3): drives UART frames
// and compares every memory write and the final status against a
// word-level reference model of the loader.
module tb_imem_uart_loader;

  localparam int CPB = 8;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic          core_rst_n;
  logic          load_done;
  logic          frame_err;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_count (word_count),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .frame_err  (frame_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: records each write, load_done during the write cycle,
  // and {load_done, core_rst_n} in the cycle after it.
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic          got_during[$];
  logic [1:0]    got_after[$];
  logic          mon_pend = 1'b0;

  always @(negedge clk) begin
    if (mon_pend) got_after.push_back({load_done, core_rst_n});
    mon_pend = imem_we;
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      got_during.push_back(load_done);
    end
  end

  // Reference model: bytes accumulate into words; each full word is written
  // at the next address; a zero word or a full memory ends loading; a bad
  // stop bit before the end stops all writing.
  int            m_cnt, m_idx;
  logic [31:0]   m_word;
  bit            m_done, m_err;
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            exp_fin[$];
  int            got_base;

  task automatic model_clear();
    m_cnt = 0; m_idx = 0; m_word = 0; m_done = 0; m_err = 0;
    exp_addr.delete(); exp_data.delete(); exp_fin.delete();
    got_base = got_addr.size();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    bit fin;
    if (m_done || m_err) return;
    if (!ok) begin
      m_err = 1;
      return;
    end
    m_word = m_word | (32'(b) << (8 * m_idx));
    m_idx++;
    if (m_idx == 4) begin
      exp_addr.push_back(AW'(m_cnt));
      exp_data.push_back(m_word);
      m_cnt++;
      fin = (m_word == 32'd0) || (m_cnt == (1 << AW));
      exp_fin.push_back(fin);
      m_done = fin;
      m_word = 0;
      m_idx  = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One UART frame; a frame with a bad stop bit is followed by an idle gap.
  task automatic send_byte(input logic [7:0] b, input bit ok);
    $display("tx byte 0x%02h stop=%0d", b, ok);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = ok;
    idle(CPB);
    if (!ok) begin
      rx = 1'b1;
      idle(2 * CPB);
    end
    model_byte(b, ok);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx  = 1'b1;
    rst = 1'b0;
    idle(2);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr_wdata", {imem_wdata[28:0], imem_addr}, 32'd0);
    check("rst_wdata_hi", 32'(imem_wdata[31:29]), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_status", {29'd0, core_rst_n, load_done, frame_err}, 32'd0);
    rst = 1'b1;
    model_clear();
    idle(2);
  endtask

  task automatic finish_scenario(input string name);
    int ng, n;
    idle(3 * CPB);
    ng = got_addr.size() - got_base;
    check({name, "_nwrites"}, 32'(ng), 32'(exp_addr.size()));
    n = (ng < exp_addr.size()) ? ng : exp_addr.size();
    if (got_after.size() - got_base < n) n = got_after.size() - got_base;
    for (int i = 0; i < n; i++) begin
      $display("%s write addr=%0d data=0x%08h", name, got_addr[got_base+i], got_data[got_base+i]);
      check({name, "_addr"}, 32'(got_addr[got_base+i]), 32'(exp_addr[i]));
      check({name, "_data"}, got_data[got_base+i], exp_data[i]);
      check({name, "_done_in_we"}, 32'(got_during[got_base+i]), 32'd0);
      check({name, "_done_after_we"}, 32'(got_after[got_base+i]), {30'd0, exp_fin[i], exp_fin[i]});
    end
    check({name, "_word_count"}, 32'(word_count), 32'(m_cnt));
    check({name, "_load_done"}, 32'(load_done), 32'(m_done));
    check({name, "_core_rst_n"}, 32'(core_rst_n), 32'(m_done));
    check({name, "_frame_err"}, 32'(frame_err), 32'(m_err));
  endtask

  typedef struct {
    logic [7:0] b [12];
    int         n;
    int         bad;      // index of the byte with a low stop bit, -1 for none
    int         exp_wc;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wb [4];
    tbl[0].b = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[0].n = 12; tbl[0].bad = -1; tbl[0].exp_wc = 3; tbl[0].exp_done = 1; tbl[0].exp_err = 0;
    tbl[1].b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h55, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].n = 12; tbl[1].bad = 4;  tbl[1].exp_wc = 1; tbl[1].exp_done = 0; tbl[1].exp_err = 1;
    tbl[2].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].n = 4;  tbl[2].bad = -1; tbl[2].exp_wc = 1; tbl[2].exp_done = 1; tbl[2].exp_err = 0;
    tbl[3].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3].n = 8;  tbl[3].bad = 5;  tbl[3].exp_wc = 1; tbl[3].exp_done = 1; tbl[3].exp_err = 0;

    // Table-driven scenarios: program load, framing error, lone terminator,
    // post-done traffic including a bad stop bit.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int k = 0; k < tbl[t].n; k++) send_byte(tbl[t].b[k], k != tbl[t].bad);
      finish_scenario($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_wc_const", t), 32'(word_count), 32'(tbl[t].exp_wc));
      check($sformatf("tbl%0d_done_const", t), 32'(load_done), 32'(tbl[t].exp_done));
      check($sformatf("tbl%0d_err_const", t), 32'(frame_err), 32'(tbl[t].exp_err));
    end

    // Glitch rejection: a 2-cycle low pulse must not start a byte.
    do_reset();
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(3 * CPB);
    check("glitch_frame_err", 32'(frame_err), 32'd0);
    check("glitch_nwrites", 32'(got_addr.size() - got_base), 32'd0);
    send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1); send_byte(8'h04, 1);
    finish_scenario("glitch");
    if (got_data.size() > got_base) check("glitch_word0_const", got_data[got_base], 32'h04030201);
    else check("glitch_word0_present", 32'(got_data.size() - got_base), 32'd1);

    // Reset mid-word discards the partial bytes.
    do_reset();
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    model_clear();
    wb = '{8'h13, 8'h05, 8'h10, 8'h00};
    for (int k = 0; k < 4; k++) send_byte(wb[k], 1);
    for (int k = 0; k < 4; k++) send_byte(8'h00, 1);
    finish_scenario("midrst");
    if (got_data.size() > got_base) check("midrst_word0_const", got_data[got_base], 32'h00100513);
    else check("midrst_word0_present", 32'(got_data.size() - got_base), 32'd2);
    check("midrst_done_const", 32'(load_done), 32'd1);

    // Memory full: 9 random nonzero words, only 8 written.
    do_reset();
    for (int w = 0; w < 9; w++) begin
      send_byte(8'($urandom_range(1, 255)), 1);
      for (int k = 1; k < 4; k++) send_byte(8'($urandom_range(0, 255)), 1);
    end
    finish_scenario("full");
    check("full_wc_const", 32'(word_count), 32'd8);
    check("full_done_const", 32'(load_done), 32'd1);

    // Random streams: occasional zero words and bad stop bits.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int w = 0; w < 6; w++) begin
        bit zero_w;
        zero_w = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < 4; k++) begin
          send_byte(zero_w ? 8'h00 : 8'($urandom_range(0, 255)), $urandom_range(0, 29) != 0);
        end
      end
      finish_scenario($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
